// File: rtl/shift_port_arbiter_if.sv
// Port bundle between two requesters, the shared shift register and shift_port_arbiter.
// Requester side: Req/Data held until its one-cycle Ack; Ack means the word is taken.
interface shift_port_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             Req0;
  logic             Req1;
  logic [WIDTH-1:0] Data0;
  logic [WIDTH-1:0] Data1;
  logic             Ack0;
  logic             Ack1;
  logic             Load;
  logic             ShiftR;
  logic             Sin;
  logic [WIDTH-1:0] Din;
  logic             Sout;
  logic             Busy;
  logic             Done;
  logic             DoneId;
  logic [WIDTH-1:0] Captured;

  modport master (
    output Req0, Req1, Data0, Data1, Sout,
    input  Ack0, Ack1, Load, ShiftR, Sin, Din, Busy, Done, DoneId, Captured
  );

  modport slave (
    input  Req0, Req1, Data0, Data1, Sout,
    output Ack0, Ack1, Load, ShiftR, Sin, Din, Busy, Done, DoneId, Captured
  );
endinterface

// File: rtl/shift_port_arbiter.sv
// Round-robin arbiter that loads the winning word into a shared shift register,
// shifts it out LSB-first and reassembles it from the looped-back Sout.
module shift_port_arbiter #(
  parameter int   WIDTH = 8,
  parameter logic FILL  = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  shift_port_arbiter_if.slave  bus,
  output logic [1:0]           state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             load_q, load_d;
  logic             shiftr_q, shiftr_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             busy_q, busy_d;
  logic             grant;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    din_d     = din_q;
    cap_d     = cap_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    load_d    = 1'b0;
    shiftr_d  = 1'b0;
    done_d    = 1'b0;
    done_id_d = 1'b0;
    grant     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          // On a tie the requester that did not win last time gets the grant.
          grant   = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;
          win_d   = grant;
          last_d  = grant;
          din_d   = grant ? bus.Data1 : bus.Data0;
          ack0_d  = ~grant;
          ack1_d  = grant;
          load_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d    = '0;
        shiftr_d = 1'b1;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        cap_d[cnt_q] = bus.Sout;
        if (cnt_q == CW'(WIDTH - 1)) begin
          done_d    = 1'b1;
          done_id_d = win_q;
          state_d   = S_DONE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          shiftr_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      cnt_q     <= '0;
      din_q     <= '0;
      cap_q     <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      load_q    <= 1'b0;
      shiftr_q  <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      cap_q     <= cap_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      load_q    <= load_d;
      shiftr_q  <= shiftr_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.Ack0     = ack0_q;
  assign bus.Ack1     = ack1_q;
  assign bus.Load     = load_q;
  assign bus.ShiftR   = shiftr_q;
  assign bus.Sin      = FILL;
  assign bus.Din      = din_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.DoneId   = done_id_q;
  assign bus.Captured = cap_q;
  assign state_dbg    = state_q;

endmodule
